// File: rtl/fsr_pkg.sv
// rtl/fsr_pkg.sv - shared FSM state type and constants for the FSR contact detector
package fsr_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESSING,
    ST_PRESSED,
    ST_RELEASING
  } fsr_state_e;

  localparam int FILT_DEPTH = 4;
  localparam int FILT_SHIFT = $clog2(FILT_DEPTH);
  localparam int SEL_W      = 4;

  function automatic logic is_contact(input fsr_state_e s);
    return (s == ST_PRESSED) || (s == ST_RELEASING);
  endfunction

endpackage

// File: rtl/fsr_channel.sv
// rtl/fsr_channel.sv - one force-sensor channel: optional 4-tap mean, hysteresis debounce FSM, display byte
// Optional feature: FSR_FILTER_EN (compare the mean of the last 4 valid samples instead of the raw sample)
module fsr_channel
  import fsr_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int DEB_CNT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] thresh_on,
  input  logic [DATA_W-1:0] thresh_off,
  output logic              contact,
  output logic              contact_event,
  output logic [7:0]        level_nxt
);

  localparam int CNT_W = $clog2(DEB_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

  logic [DATA_W-1:0] cmp_val;

`ifdef FSR_FILTER_EN
  logic [FILT_DEPTH-2:0][DATA_W-1:0] hist;
  logic [DATA_W+FILT_SHIFT-1:0]      sum;

  always_comb begin
    sum = (DATA_W+FILT_SHIFT)'(sample);
    for (int i = 0; i < FILT_DEPTH - 1; i++) begin
      sum = sum + (DATA_W+FILT_SHIFT)'(hist[i]);
    end
  end

  assign cmp_val = DATA_W'(sum >> FILT_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
    end else if (sample_valid) begin
      hist <= {hist[FILT_DEPTH-3:0], sample};
    end
  end
`else
  assign cmp_val = sample;
`endif

  logic is_high;
  logic is_low;
  assign is_high = cmp_val > thresh_on;
  assign is_low  = cmp_val < thresh_off;

  fsr_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             contact_nxt;
  logic [7:0]       level_q;

  // A run of DEB_CNT qualifying strobes changes state; any break in the run restarts it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (sample_valid) begin
      unique case (state)
        ST_RELEASED: begin
          cnt_nxt = '0;
          if (is_high) begin
            if (CNT_LAST == '0) begin
              state_nxt = ST_PRESSED;
            end else begin
              state_nxt = ST_PRESSING;
              cnt_nxt   = CNT_W'(1);
            end
          end
        end
        ST_PRESSING: begin
          if (!is_high) begin
            state_nxt = ST_RELEASED;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = ST_PRESSED;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        ST_PRESSED: begin
          cnt_nxt = '0;
          if (is_low) begin
            if (CNT_LAST == '0) begin
              state_nxt = ST_RELEASED;
            end else begin
              state_nxt = ST_RELEASING;
              cnt_nxt   = CNT_W'(1);
            end
          end
        end
        ST_RELEASING: begin
          if (!is_low) begin
            state_nxt = ST_PRESSED;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = ST_RELEASED;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = ST_RELEASED;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign contact_nxt = is_contact(state_nxt);

  // Only the displayed byte of the latest compared value is ever read back.
  assign level_nxt = sample_valid ? cmp_val[DATA_W-1 -: 8] : level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_RELEASED;
      cnt           <= '0;
      contact       <= 1'b0;
      contact_event <= 1'b0;
      level_q       <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      contact       <= contact_nxt;
      contact_event <= contact_nxt ^ contact;
      level_q       <= level_nxt;
    end
  end

endmodule

// File: rtl/fsr_contact_detect.sv
// rtl/fsr_contact_detect.sv - multi-channel FSR contact detector with selectable level/flag display
// Optional feature: FSR_FILTER_EN (enables the per-channel 4-sample mean in fsr_channel)
module fsr_contact_detect
  import fsr_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 12,
  parameter int DEB_CNT = 4
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     SAMPLE_VALID,
  input  logic [NUM_CH*DATA_W-1:0] SAMPLE_DATA,
  input  logic [DATA_W-1:0]        THRESH_ON,
  input  logic [DATA_W-1:0]        THRESH_OFF,
  input  logic [SEL_W-1:0]         SEL,
  output logic [7:0]               LEVEL,
  output logic [NUM_CH-1:0]        CONTACT,
  output logic [NUM_CH-1:0]        CONTACT_EVENT,
  output logic                     FSR_flag
);

  localparam int SEL_SPAN = 1 << SEL_W;

  // Padding the display muxes to the full SEL range makes unpopulated selections read as zero.
  logic [SEL_SPAN-1:0][7:0] level_nxt;
  logic [SEL_SPAN-1:0]      contact_pad;

  genvar k;
  generate
    for (k = 0; k < SEL_SPAN; k++) begin : g_ch
      if (k < NUM_CH) begin : g_live
        fsr_channel #(
          .DATA_W  (DATA_W),
          .DEB_CNT (DEB_CNT)
        ) u_channel (
          .clk           (CLOCK),
          .rst           (RESET),
          .sample_valid  (SAMPLE_VALID),
          .sample        (SAMPLE_DATA[k*DATA_W +: DATA_W]),
          .thresh_on     (THRESH_ON),
          .thresh_off    (THRESH_OFF),
          .contact       (CONTACT[k]),
          .contact_event (CONTACT_EVENT[k]),
          .level_nxt     (level_nxt[k])
        );
        assign contact_pad[k] = CONTACT[k];
      end else begin : g_pad
        assign level_nxt[k]   = '0;
        assign contact_pad[k] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      LEVEL    <= '0;
      FSR_flag <= 1'b0;
    end else begin
      LEVEL    <= level_nxt[SEL];
      FSR_flag <= contact_pad[SEL];
    end
  end

endmodule

// File: tb/tb_fsr_contact_detect.sv
// tb/tb_fsr_contact_detect.sv - directed self-checking bench for fsr_contact_detect
module tb_fsr_contact_detect;

  localparam int NUM_CH  = 8;
  localparam int DATA_W  = 12;
  localparam int DEB_CNT = 4;

  logic                     CLOCK = 1'b0;
  logic                     RESET = 1'b1;
  logic                     SAMPLE_VALID = 1'b0;
  logic [NUM_CH*DATA_W-1:0] SAMPLE_DATA = '0;
  logic [DATA_W-1:0]        THRESH_ON = 12'h400;
  logic [DATA_W-1:0]        THRESH_OFF = 12'h300;
  logic [3:0]               SEL = 4'd0;
  logic [7:0]               LEVEL;
  logic [NUM_CH-1:0]        CONTACT;
  logic [NUM_CH-1:0]        CONTACT_EVENT;
  logic                     FSR_flag;

  int checks = 0;
  int failures = 0;
  int ev4_cnt = 0;

  fsr_contact_detect #(
    .NUM_CH  (NUM_CH),
    .DATA_W  (DATA_W),
    .DEB_CNT (DEB_CNT)
  ) dut (
    .CLOCK         (CLOCK),
    .RESET         (RESET),
    .SAMPLE_VALID  (SAMPLE_VALID),
    .SAMPLE_DATA   (SAMPLE_DATA),
    .THRESH_ON     (THRESH_ON),
    .THRESH_OFF    (THRESH_OFF),
    .SEL           (SEL),
    .LEVEL         (LEVEL),
    .CONTACT       (CONTACT),
    .CONTACT_EVENT (CONTACT_EVENT),
    .FSR_flag      (FSR_flag)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CONTACT_EVENT[4]) ev4_cnt++;

  task automatic set_ch(input int k, input logic [DATA_W-1:0] v);
    SAMPLE_DATA[k*DATA_W +: DATA_W] = v;
  endtask

  // Called at a falling edge; returns at the falling edge after the n-th strobe.
  task automatic strobe(input int n);
    for (int i = 0; i < n; i++) begin
      SAMPLE_VALID = 1'b1;
      @(negedge CLOCK);
      SAMPLE_VALID = 1'b0;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLOCK);
    checks++; if (LEVEL !== 8'h00) begin failures++; $display("FAIL reset_level got=%h exp=00", LEVEL); end
    checks++; if (CONTACT !== 8'h00) begin failures++; $display("FAIL reset_contact got=%h exp=00", CONTACT); end
    checks++; if (CONTACT_EVENT !== 8'h00) begin failures++; $display("FAIL reset_event got=%h exp=00", CONTACT_EVENT); end
    checks++; if (FSR_flag !== 1'b0) begin failures++; $display("FAIL reset_flag got=%b exp=0", FSR_flag); end
    RESET = 1'b0;
    @(negedge CLOCK);
  endtask

  task automatic test_press();
    set_ch(2, 12'h500);
    strobe(3);
    checks++; if (CONTACT !== 8'h00) begin failures++; $display("FAIL press_3 got=%h exp=00", CONTACT); end
    strobe(1);
    checks++; if (CONTACT !== 8'h04) begin failures++; $display("FAIL press_4 got=%h exp=04", CONTACT); end
    checks++; if (CONTACT_EVENT !== 8'h04) begin failures++; $display("FAIL press_event got=%h exp=04", CONTACT_EVENT); end
    @(negedge CLOCK);
    checks++; if (CONTACT_EVENT !== 8'h00) begin failures++; $display("FAIL press_event_end got=%h exp=00", CONTACT_EVENT); end
    checks++; if (CONTACT !== 8'h04) begin failures++; $display("FAIL press_hold got=%h exp=04", CONTACT); end
  endtask

  task automatic test_release();
    set_ch(2, 12'h200);
    strobe(3);
    checks++; if (CONTACT !== 8'h04) begin failures++; $display("FAIL release_run1 got=%h exp=04", CONTACT); end
    set_ch(2, 12'h350);
    strobe(1);
    checks++; if (CONTACT !== 8'h04) begin failures++; $display("FAIL release_inband got=%h exp=04", CONTACT); end
    set_ch(2, 12'h200);
    strobe(3);
    checks++; if (CONTACT !== 8'h04) begin failures++; $display("FAIL release_run2_3 got=%h exp=04", CONTACT); end
    checks++; if (CONTACT_EVENT !== 8'h00) begin failures++; $display("FAIL release_no_event got=%h exp=00", CONTACT_EVENT); end
    strobe(1);
    checks++; if (CONTACT !== 8'h00) begin failures++; $display("FAIL release_done got=%h exp=00", CONTACT); end
    checks++; if (CONTACT_EVENT !== 8'h04) begin failures++; $display("FAIL release_event got=%h exp=04", CONTACT_EVENT); end
    @(negedge CLOCK);
    checks++; if (CONTACT_EVENT !== 8'h00) begin failures++; $display("FAIL release_event_end got=%h exp=00", CONTACT_EVENT); end
  endtask

  task automatic test_thresholds();
    set_ch(3, 12'h400);
    strobe(6);
    checks++; if (CONTACT !== 8'h00) begin failures++; $display("FAIL thr_on_equal got=%h exp=00", CONTACT); end
    set_ch(3, 12'h401);
    strobe(4);
    checks++; if (CONTACT !== 8'h08) begin failures++; $display("FAIL thr_on_above got=%h exp=08", CONTACT); end
    set_ch(3, 12'h300);
    strobe(6);
    checks++; if (CONTACT !== 8'h08) begin failures++; $display("FAIL thr_off_equal got=%h exp=08", CONTACT); end
    set_ch(3, 12'h2FF);
    strobe(4);
    checks++; if (CONTACT !== 8'h00) begin failures++; $display("FAIL thr_off_below got=%h exp=00", CONTACT); end
  endtask

  task automatic test_inband();
    set_ch(4, 12'h380);
    strobe(20);
    #1;
    checks++; if (CONTACT !== 8'h00) begin failures++; $display("FAIL inband_released got=%h exp=00", CONTACT); end
    checks++; if (ev4_cnt !== 0) begin failures++; $display("FAIL inband_released_events got=%0d exp=0", ev4_cnt); end
    @(negedge CLOCK);
    set_ch(4, 12'h500);
    strobe(4);
    set_ch(4, 12'h380);
    strobe(20);
    #1;
    checks++; if (CONTACT !== 8'h10) begin failures++; $display("FAIL inband_pressed got=%h exp=10", CONTACT); end
    checks++; if (ev4_cnt !== 1) begin failures++; $display("FAIL inband_pressed_events got=%0d exp=1", ev4_cnt); end
    @(negedge CLOCK);
  endtask

  task automatic test_level_sel();
    SEL = 4'd5;
    set_ch(5, 12'hABC);
    strobe(1);
    checks++; if (LEVEL !== 8'hAB) begin failures++; $display("FAIL level_ch5 got=%h exp=ab", LEVEL); end
    checks++; if (FSR_flag !== 1'b0) begin failures++; $display("FAIL flag_ch5 got=%b exp=0", FSR_flag); end
    set_ch(5, 12'h000);
    SEL = 4'd4;
    @(negedge CLOCK);
    checks++; if (LEVEL !== 8'h38) begin failures++; $display("FAIL level_ch4 got=%h exp=38", LEVEL); end
    checks++; if (FSR_flag !== 1'b1) begin failures++; $display("FAIL flag_ch4 got=%b exp=1", FSR_flag); end
    SEL = 4'd9;
    @(negedge CLOCK);
    checks++; if (LEVEL !== 8'h00) begin failures++; $display("FAIL level_sel9 got=%h exp=00", LEVEL); end
    checks++; if (FSR_flag !== 1'b0) begin failures++; $display("FAIL flag_sel9 got=%b exp=0", FSR_flag); end
    SEL = 4'd5;
    @(negedge CLOCK);
    checks++; if (LEVEL !== 8'hAB) begin failures++; $display("FAIL level_ch5_held got=%h exp=ab", LEVEL); end
    SEL = 4'd4;
    @(negedge CLOCK);
  endtask

  task automatic test_reset_midrun();
    set_ch(0, 12'h500);
    strobe(3);
    checks++; if (CONTACT !== 8'h10) begin failures++; $display("FAIL midrun_pre got=%h exp=10", CONTACT); end
    #2 RESET = 1'b1;
    #1;
    checks++; if (CONTACT !== 8'h00) begin failures++; $display("FAIL midrun_contact got=%h exp=00", CONTACT); end
    checks++; if (LEVEL !== 8'h00) begin failures++; $display("FAIL midrun_level got=%h exp=00", LEVEL); end
    checks++; if (FSR_flag !== 1'b0) begin failures++; $display("FAIL midrun_flag got=%b exp=0", FSR_flag); end
    @(negedge CLOCK);
    RESET = 1'b0;
    @(negedge CLOCK);
    strobe(3);
    checks++; if (CONTACT !== 8'h00) begin failures++; $display("FAIL midrun_3 got=%h exp=00", CONTACT); end
    strobe(1);
    checks++; if (CONTACT !== 8'h01) begin failures++; $display("FAIL midrun_4 got=%h exp=01", CONTACT); end
    checks++; if (CONTACT_EVENT !== 8'h01) begin failures++; $display("FAIL midrun_event got=%h exp=01", CONTACT_EVENT); end
  endtask

`ifdef FSR_FILTER_EN
  task automatic test_filter();
    logic [7:0] exp_lvl [4];
    exp_lvl = '{8'h20, 8'h40, 8'h60, 8'h80};
    SEL = 4'd1;
    set_ch(1, 12'h800);
    for (int i = 0; i < 4; i++) begin
      strobe(1);
      checks++; if (LEVEL !== exp_lvl[i]) begin failures++; $display("FAIL filter_mean_%0d got=%h exp=%h", i, LEVEL, exp_lvl[i]); end
    end
    strobe(1);
    checks++; if (CONTACT !== 8'h00) begin failures++; $display("FAIL filter_5 got=%h exp=00", CONTACT); end
    strobe(1);
    checks++; if (CONTACT !== 8'h02) begin failures++; $display("FAIL filter_6 got=%h exp=02", CONTACT); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef FSR_FILTER_EN
    test_filter();
`else
    test_press();
    test_release();
    test_thresholds();
    test_inband();
    test_level_sel();
    test_reset_midrun();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
